mult_hilo_ctrl: RTL and testbench
=================================

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have In_Valid (input, 1, issue request) and In_Ready (output, 1, unit can accept).
REQ-004 SHALL have OpA and OpB (input, 16, multiplicand / multiplier) and Signed_Op (input, 1, signed multiply request).
REQ-005 SHALL have Wr_Hi, Wr_Lo (input, 1, MTHI/MTLO strobes) and Wr_Data (input, 16).
REQ-006 SHALL have Mul_St (output, 1), Mul_A and Mul_B (output, 16) driving the multiplier; Mul_Idle, Mul_Done (input, 1) and Mul_Produto (input, 32) from it.
REQ-007 SHALL have Hi and Lo (output, 16, product halves), Busy (output, 1), Res_Valid (output, 1, one-cycle completion pulse), Err (output, 1, one-cycle timeout/illegal-write pulse).
REQ-008 SHALL have parameter TIMEOUT, default 40, maximum cycles in WAIT before abort.

Function
REQ-009 SHALL implement FSM states IDLE, START, WAIT, WRITE.
REQ-010 IDLE: In_Ready=1; In_Valid=1 SHALL register operands into Mul_A/Mul_B and move to START next edge.
REQ-011 START: Mul_St=1; SHALL stay until Mul_Idle=0 is sampled, then go to WAIT.
REQ-012 WAIT: Mul_St=0; timeout counter increments each cycle; Mul_Done=1 SHALL capture Mul_Produto and go to WRITE.
REQ-013 WRITE: Hi<=product[31:16], Lo<=product[15:0], Res_Valid=1 for that cycle, return to IDLE.
REQ-014 Mul_A/Mul_B SHALL hold stable from START entry until WRITE exit.
REQ-015 Busy SHALL equal 1 in START, WAIT, WRITE; In_Ready SHALL equal NOT Busy.
REQ-016 Latency: accept edge N -> Res_Valid at edge N+k+3 where k is multiplier Done latency after St; Hi/Lo visible same cycle as Res_Valid.
REQ-017 Counter reaching TIMEOUT in START or WAIT SHALL pulse Err, leave Hi/Lo unchanged, return to IDLE.
REQ-018 Wr_Hi/Wr_Lo in IDLE SHALL load Wr_Data into Hi/Lo next edge; both asserted loads both.
REQ-019 Wr_Hi/Wr_Lo while Busy SHALL be ignored and pulse Err.
REQ-020 In_Valid and Wr_Hi in same IDLE cycle: write applied and request accepted; product later overwrites.
REQ-021 Mul_Done seen in IDLE or START SHALL be ignored.

Reset
REQ-022 Rst_n=0 SHALL force IDLE, Hi=Lo=0, Mul_A=Mul_B=0, Mul_St=0, Res_Valid=0, Err=0, counter=0, also mid-operation; no result write follows.
REQ-023 First acceptance after reset release SHALL occur no earlier than first edge with Rst_n=1.

Configuration
REQ-024 Macro MULT_SIGNED_EN defined: Signed_Op=1 SHALL send |OpA|, |OpB| to multiplier and two's-complement negate the 32-bit product when operand signs differ; 0x8000 magnitude is 0x8000.
REQ-025 MULT_SIGNED_EN undefined: Signed_Op SHALL be ignored; all operations unsigned; no negation logic present.

Structure
REQ-026 FSM state encoding, TIMEOUT default and HI/LO half-width constant SHALL reside in shared package mult_pkg.
REQ-027 Sign pre/post-processing SHALL be sub-module mult_sign_adj, instantiated only under MULT_SIGNED_EN.

Verification
REQ-028 OpA=3, OpB=5, unsigned -> Res_Valid once, Hi=0x0000, Lo=0x000F.
REQ-029 OpA=0xFFFF, OpB=0xFFFF, unsigned -> Hi=0xFFFE, Lo=0x0001.
REQ-030 MULT_SIGNED_EN, Signed_Op=1, OpA=0xFFFD(-3), OpB=5 -> Mul_A=3, Hi=0xFFFF, Lo=0xFFF1; OpA=OpB=0x8000 -> Hi=0x4000, Lo=0x0000.
REQ-031 Multiplier model never asserts Mul_Done -> Err pulse TIMEOUT cycles after START entry, Hi/Lo unchanged, In_Ready=1 next cycle.
REQ-032 Wr_Hi=1, Wr_Data=0x1234 in WAIT -> Err pulse, Hi unchanged; same in IDLE -> Hi=0x1234.
REQ-033 Rst_n low during WAIT, then Mul_Done -> no Res_Valid, Hi=Lo=0, state IDLE.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 40;
  localparam int HALF_W          = 16;
  localparam int FULL_W          = 2 * HALF_W;

endpackage

// File: rtl/mult_sign_adj.sv
// Sign/magnitude adjustment around an unsigned multiplier (built only with MULT_SIGNED_EN).
module mult_sign_adj
  import mult_pkg::*;
(
  input  logic [HALF_W-1:0] opa,
  input  logic [HALF_W-1:0] opb,
  input  logic              signed_op,
  input  logic              neg_q,
  input  logic [FULL_W-1:0] prod_in,
  output logic [HALF_W-1:0] mag_a,
  output logic [HALF_W-1:0] mag_b,
  output logic              neg_d,
  output logic [FULL_W-1:0] prod_out
);

  // -0x8000 wraps back to 0x8000, which is the correct unsigned magnitude.
  assign mag_a    = (signed_op && opa[HALF_W-1]) ? -opa : opa;
  assign mag_b    = (signed_op && opb[HALF_W-1]) ? -opb : opb;
  assign neg_d    = signed_op && (opa[HALF_W-1] ^ opb[HALF_W-1]);
  assign prod_out = neg_q ? -prod_in : prod_in;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Multiply controller: sequences an external multiplier and owns the HI/LO result pair.
// Define MULT_SIGNED_EN to add signed multiplies through mult_sign_adj.
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [HALF_W-1:0] OpA,
  input  logic [HALF_W-1:0] OpB,
  input  logic              Signed_Op,
  input  logic              Wr_Hi,
  input  logic              Wr_Lo,
  input  logic [HALF_W-1:0] Wr_Data,
  output logic              Mul_St,
  output logic [HALF_W-1:0] Mul_A,
  output logic [HALF_W-1:0] Mul_B,
  input  logic              Mul_Idle,
  input  logic              Mul_Done,
  input  logic [FULL_W-1:0] Mul_Produto,
  output logic [HALF_W-1:0] Hi,
  output logic [HALF_W-1:0] Lo,
  output logic              Busy,
  output logic              Res_Valid,
  output logic              Err
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [HALF_W-1:0] hi_q, lo_q, mul_a_q, mul_b_q;
  logic [HALF_W-1:0] mag_a, mag_b;
  logic [FULL_W-1:0] prod_adj;
  logic              err_q, busy, accept, capture, timeout;

`ifdef MULT_SIGNED_EN
  logic neg_d, neg_q;

  mult_sign_adj u_sign_adj (
    .opa      (OpA),
    .opb      (OpB),
    .signed_op(Signed_Op),
    .neg_q    (neg_q),
    .prod_in  (Mul_Produto),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg_d    (neg_d),
    .prod_out (prod_adj)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_d;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = Signed_Op;
  assign mag_a            = OpA;
  assign mag_b            = OpB;
  assign prod_adj         = Mul_Produto;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Mul_Done is only honoured in WAIT; a completion wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (In_Valid) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (!Mul_Idle) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (Mul_Done) begin
          capture = 1'b1;
          state_d = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // HI/LO are loaded on WRITE entry so the result is visible alongside Res_Valid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout | (busy & (Wr_Hi | Wr_Lo));
      if (accept) begin
        mul_a_q <= mag_a;
        mul_b_q <= mag_b;
        cnt_q   <= '0;
      end else if (state_q == START || state_q == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (capture) begin
        hi_q <= prod_adj[FULL_W-1:HALF_W];
        lo_q <= prod_adj[HALF_W-1:0];
      end else if (!busy) begin
        if (Wr_Hi) hi_q <= Wr_Data;
        if (Wr_Lo) lo_q <= Wr_Data;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign Busy      = busy;
  assign In_Ready  = ~busy;
  assign Mul_St    = (state_q == START);
  assign Res_Valid = (state_q == WRITE);
  assign Err       = err_q;
  assign Mul_A     = mul_a_q;
  assign Mul_B     = mul_b_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Randomized scoreboard bench for mult_hilo_ctrl with a behavioural multiplier and HI/LO model.
module tb_mult_hilo_ctrl;

  localparam int TO = 40;

  logic        Clk, Rst_n, In_Valid, In_Ready, Signed_Op, Wr_Hi, Wr_Lo;
  logic [15:0] OpA, OpB, Wr_Data, Mul_A, Mul_B, Hi, Lo;
  logic        Mul_St, Mul_Idle, Busy, Res_Valid, Err;
  logic        Mul_Done    = 1'b0;
  logic [31:0] Mul_Produto = '0;

  mult_hilo_ctrl #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .OpA(OpA), .OpB(OpB), .Signed_Op(Signed_Op),
    .Wr_Hi(Wr_Hi), .Wr_Lo(Wr_Lo), .Wr_Data(Wr_Data),
    .Mul_St(Mul_St), .Mul_A(Mul_A), .Mul_B(Mul_B),
    .Mul_Idle(Mul_Idle), .Mul_Done(Mul_Done), .Mul_Produto(Mul_Produto),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Res_Valid(Res_Valid), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nPass   = 0;
  logic [31:0] resQ[$];
  int          errQ[$];
  logic [15:0] refHi = '0;
  logic [15:0] refLo = '0;

  // Unsigned multiplier: goes busy when it samples St, pulses Done mulLat edges later.
  logic        mBusy    = 1'b0;
  int          mLeft    = 0;
  logic [31:0] mProd    = '0;
  int          mulLat   = 1;
  bit          mulHang  = 1'b0;
  bit          mdlAbort = 1'b0;

  assign Mul_Idle = ~mBusy;

  always @(posedge Clk) begin
    Mul_Done <= 1'b0;
    if (mdlAbort) begin
      mBusy <= 1'b0;
    end else if (mBusy) begin
      if (!mulHang) begin
        if (mLeft <= 1) begin
          Mul_Done    <= 1'b1;
          Mul_Produto <= mProd;
          mBusy       <= 1'b0;
        end else begin
          mLeft <= mLeft - 1;
        end
      end
    end else if (Mul_St) begin
      mBusy <= 1'b1;
      mLeft <= mulLat;
      mProd <= 32'(Mul_A) * 32'(Mul_B);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act === expv) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  function automatic logic [31:0] refProduct(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint ua, ub;
`ifdef MULT_SIGNED_EN
    int ia, ib;
    if (s) begin
      ia = $signed(a);
      ib = $signed(b);
      return 32'(ia * ib);
    end
`endif
    ua = longint'(a);
    ub = longint'(b);
    return 32'(ua * ub);
  endfunction

  function automatic logic [15:0] refMag(input logic [15:0] v, input logic s);
`ifdef MULT_SIGNED_EN
    int iv;
    iv = $signed(v);
    if (s && iv < 0) iv = -iv;
    return 16'(iv);
`else
    return s ? v : v;
`endif
  endfunction

  // Monitor: every Res_Valid/Err pulse must match an entry the stimulus queued.
  always @(negedge Clk) begin
    logic [31:0] e;
    if (Rst_n) begin
      if (Res_Valid) begin
        checkOutput("res_expected", 32'(resQ.size() != 0), 32'd1);
        if (resQ.size() != 0) begin
          e = resQ.pop_front();
          checkOutput("hi_lo_result", {Hi, Lo}, e);
          refHi = e[31:16];
          refLo = e[15:0];
        end
      end
      if (Err) begin
        checkOutput("err_expected", 32'(errQ.size() != 0), 32'd1);
        if (errQ.size() != 0) begin
          void'(errQ.pop_front());
          checkOutput("hi_lo_on_err", {Hi, Lo}, {refHi, refLo});
        end
      end
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 60 && !In_Ready; i++) @(negedge Clk);
    checkOutput("ready_for_issue", 32'(In_Ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s,
                               input int lat, input bit hang, input int wrBusyAt,
                               input bit wrSame, input logic [15:0] wdata);
    logic [15:0] ea, eb;
    int resAt, errAt, bad;
    bit done;
    waitReady();
    ea = refMag(a, s);
    eb = refMag(b, s);
    In_Valid  = 1'b1;
    OpA       = a;
    OpB       = b;
    Signed_Op = s;
    mulLat    = lat;
    mulHang   = hang;
    if (wrSame) begin
      Wr_Hi   = 1'b1;
      Wr_Data = wdata;
    end
    if (hang) errQ.push_back(1);
    else resQ.push_back(refProduct(a, b, s));
    @(posedge Clk);
    if (wrSame) refHi = wdata;
    resAt = 0; errAt = 0; bad = 0; done = 1'b0;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        In_Valid = 1'b0;
        Wr_Hi    = 1'b0;
        checkOutput("mul_ab_issue", {Mul_A, Mul_B}, {ea, eb});
        if (wrSame) checkOutput("wr_same_hi", 32'(Hi), 32'(wdata));
      end
      if (Busy && {Mul_A, Mul_B} != {ea, eb}) bad++;
      if (wrBusyAt != 0 && c == wrBusyAt) begin
        Wr_Hi   = 1'b1;
        Wr_Data = 16'h1234;
        errQ.push_back(1);
      end else if (wrBusyAt != 0 && c == wrBusyAt + 1) begin
        Wr_Hi = 1'b0;
      end
      if (Res_Valid && resAt == 0) resAt = c;
      if (Err && hang && errAt == 0) errAt = c;
      if (c > 1 && In_Ready) done = 1'b1;
    end
    checkOutput("op_done", 32'(In_Ready), 32'd1);
    checkOutput("mul_ab_stable", 32'(bad), 32'd0);
    // Counts are negedges after the accept edge: Res_Valid is sampled at edge N+k+3,
    // Err rises when the START/WAIT counter reaches TIMEOUT.
    if (hang) begin
      checkOutput("timeout_at", 32'(errAt), 32'(TO + 1));
      @(negedge Clk);
      checkOutput("ready_after_timeout", 32'(In_Ready), 32'd1);
      mdlAbort = 1'b1;
      @(negedge Clk);
      mdlAbort = 1'b0;
      mulHang  = 1'b0;
    end else begin
      checkOutput("latency", 32'(resAt), 32'(lat + 3));
    end
  endtask

  task automatic writeHiLo(input logic h, input logic l, input logic [15:0] d);
    waitReady();
    Wr_Hi   = h;
    Wr_Lo   = l;
    Wr_Data = d;
    @(posedge Clk);
    if (h) refHi = d;
    if (l) refLo = d;
    @(negedge Clk);
    Wr_Hi = 1'b0;
    Wr_Lo = 1'b0;
    checkOutput("idle_write", {Hi, Lo}, {refHi, refLo});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hilo"}, {Hi, Lo}, 32'd0);
    checkOutput({tag, "_mul_ab"}, {Mul_A, Mul_B}, 32'd0);
    checkOutput({tag, "_ctrl"}, 32'({Mul_St, Res_Valid, Err, Busy, In_Ready}), 32'b00001);
  endtask

  task automatic resetDuringWait();
    waitReady();
    In_Valid  = 1'b1;
    OpA       = 16'h00AB;
    OpB       = 16'h0102;
    Signed_Op = 1'b0;
    mulLat    = 20;
    @(posedge Clk);
    @(negedge Clk);
    In_Valid = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("in_wait_state", 32'({Busy, Mul_St}), 32'b10);
    Rst_n = 1'b0;
    @(negedge Clk);
    checkResetState("mid_reset");
    Rst_n = 1'b1;
    refHi = '0;
    refLo = '0;
    repeat (30) @(negedge Clk);
    checkOutput("hilo_after_late_done", {Hi, Lo}, 32'd0);
    checkOutput("idle_after_late_done", 32'(In_Ready), 32'd1);
  endtask

  initial begin
    Rst_n     = 1'b0;
    In_Valid  = 1'b0;
    OpA       = '0;
    OpB       = '0;
    Signed_Op = 1'b0;
    Wr_Hi     = 1'b0;
    Wr_Lo     = 1'b0;
    Wr_Data   = '0;
    repeat (3) @(negedge Clk);
    checkResetState("reset");
    Rst_n = 1'b1;
    $display("[TB] reset released");

    applyStimulus(16'd3, 16'd5, 1'b0, 2, 1'b0, 0, 1'b0, 16'h0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 4, 1'b0, 0, 1'b0, 16'h0);
`ifdef MULT_SIGNED_EN
    applyStimulus(16'hFFFD, 16'd5, 1'b1, 3, 1'b0, 0, 1'b0, 16'h0);
    applyStimulus(16'h8000, 16'h8000, 1'b1, 2, 1'b0, 0, 1'b0, 16'h0);
    applyStimulus(16'h0007, 16'hFFF9, 1'b1, 1, 1'b0, 0, 1'b0, 16'h0);
`endif
    writeHiLo(1'b1, 1'b0, 16'h1234);
    writeHiLo(1'b0, 1'b1, 16'hABCD);
    writeHiLo(1'b1, 1'b1, 16'h5A5A);

    $display("[TB] multiplier hang");
    applyStimulus(16'h0102, 16'h0304, 1'b0, 1, 1'b1, 0, 1'b0, 16'h0);

    $display("[TB] write while busy");
    applyStimulus(16'h0011, 16'h0022, 1'b0, 8, 1'b0, 3, 1'b0, 16'h0);

    $display("[TB] write and issue in one cycle");
    applyStimulus(16'h0100, 16'h0009, 1'b0, 3, 1'b0, 0, 1'b1, 16'h7777);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 6)), 1'b0, 0, 1'b0, 16'h0);
    end

    $display("[TB] reset during wait");
    resetDuringWait();

    repeat (2) @(negedge Clk);
    checkOutput("scoreboard_drained", 32'(resQ.size() + errQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
